id_ex_stage: RTL

ID/EX pipeline register with load-use hazard detection for the 8-register pipelined CPU. It captures decoded operands and control from ID and presents them to EX: register numbers to the forwarding unit, operands and control to the ALU. On a load-use hazard or a branch flush it inserts a bubble. It also drives the `ID_EX_flush` qualifier and the front-end `stall`.

---
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 102 ++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields and WB bypass in, registered EX fields and stall out.
// Master drives the ID/WB side; slave is the id_ex_stage register itself.
interface id_ex_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
);
  localparam int unsigned ALUOP_W = 3;

  logic               ID_valid;
  logic [RW-1:0]      ID_RegRs;
  logic [RW-1:0]      ID_RegRt;
  logic [RW-1:0]      ID_RegRd;
  logic               ID_UsesRt;
  logic [DW-1:0]      ID_RsData;
  logic [DW-1:0]      ID_RtData;
  logic [DW-1:0]      ID_Imm;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic               ID_ALUSrc;
  logic               ID_RegWrite;
  logic               ID_MemRead;
  logic               ID_MemWrite;
  logic               WB_RegWrite;
  logic [RW-1:0]      WB_RegRd;
  logic [DW-1:0]      WB_Data;
  logic               branch_flush;

  logic [RW-1:0]      EX_RegRs;
  logic [RW-1:0]      EX_RegRt;
  logic [RW-1:0]      EX_RegRd;
  logic [DW-1:0]      EX_RsData;
  logic [DW-1:0]      EX_RtData;
  logic [DW-1:0]      EX_Imm;
  logic [ALUOP_W-1:0] EX_ALUOp;
  logic               EX_ALUSrc;
  logic               EX_RegWrite;
  logic               EX_MemRead;
  logic               EX_MemWrite;
  logic               EX_valid;
  logic               ID_EX_flush;
  logic               stall;

  modport master (
    output ID_valid, ID_RegRs, ID_RegRt, ID_RegRd, ID_UsesRt,
           ID_RsData, ID_RtData, ID_Imm, ID_ALUOp,
           ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite,
           WB_RegWrite, WB_RegRd, WB_Data, branch_flush,
    input  EX_RegRs, EX_RegRt, EX_RegRd, EX_RsData, EX_RtData, EX_Imm,
           EX_ALUOp, EX_ALUSrc, EX_RegWrite, EX_MemRead, EX_MemWrite,
           EX_valid, ID_EX_flush, stall
  );

  modport slave (
    input  ID_valid, ID_RegRs, ID_RegRt, ID_RegRd, ID_UsesRt,
           ID_RsData, ID_RtData, ID_Imm, ID_ALUOp,
           ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite,
           WB_RegWrite, WB_RegRd, WB_Data, branch_flush,
    output EX_RegRs, EX_RegRt, EX_RegRd, EX_RsData, EX_RtData, EX_Imm,
           EX_ALUOp, EX_ALUSrc, EX_RegWrite, EX_MemRead, EX_MemWrite,
           EX_valid, ID_EX_flush, stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall, branch-flush bubble and WB write-through.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module id_ex_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]   stall_count
`endif
);

  localparam logic [RW-1:0] REG_ZERO = RW'(0);

  logic          hazard;
  logic          bubble;
  logic          rs_bypass;
  logic          rt_bypass;
  logic [DW-1:0] rs_cap;
  logic [DW-1:0] rt_cap;

  // Load in EX whose destination feeds the ID instruction; register 0 never hazards
  always_comb begin
    hazard    = 1'b0;
    bus.stall = 1'b0;
    bubble    = 1'b0;
    rs_bypass = 1'b0;
    rt_bypass = 1'b0;
    rs_cap    = bus.ID_RsData;
    rt_cap    = bus.ID_RtData;

    hazard = bus.EX_valid & bus.EX_MemRead & (bus.EX_RegRd != REG_ZERO) & bus.ID_valid &
             ((bus.EX_RegRd == bus.ID_RegRs) |
              (bus.ID_UsesRt & (bus.EX_RegRd == bus.ID_RegRt)));
    bus.stall = hazard & ~bus.branch_flush;
    bubble    = bus.branch_flush | hazard | ~bus.ID_valid;

    // Register file is written at the same edge it is read; forward the WB value
    rs_bypass = bus.WB_RegWrite & (bus.WB_RegRd != REG_ZERO) & (bus.WB_RegRd == bus.ID_RegRs);
    rt_bypass = bus.WB_RegWrite & (bus.WB_RegRd != REG_ZERO) & (bus.WB_RegRd == bus.ID_RegRt);
    if (rs_bypass) rs_cap = bus.WB_Data;
    if (rt_bypass) rt_cap = bus.WB_Data;
  end

  assign bus.ID_EX_flush = ~bus.EX_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.EX_valid    <= 1'b0;
      bus.EX_RegRs    <= '0;
      bus.EX_RegRt    <= '0;
      bus.EX_RegRd    <= '0;
      bus.EX_RsData   <= '0;
      bus.EX_RtData   <= '0;
      bus.EX_Imm      <= '0;
      bus.EX_ALUOp    <= '0;
      bus.EX_ALUSrc   <= 1'b0;
      bus.EX_RegWrite <= 1'b0;
      bus.EX_MemRead  <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
    end else if (bubble) begin
      // Bubble: kill control and register numbers; data fields are don't-care and hold
      bus.EX_valid    <= 1'b0;
      bus.EX_RegRs    <= '0;
      bus.EX_RegRt    <= '0;
      bus.EX_RegRd    <= '0;
      bus.EX_ALUOp    <= '0;
      bus.EX_ALUSrc   <= 1'b0;
      bus.EX_RegWrite <= 1'b0;
      bus.EX_MemRead  <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
    end else begin
      bus.EX_valid    <= 1'b1;
      bus.EX_RegRs    <= bus.ID_RegRs;
      bus.EX_RegRt    <= bus.ID_RegRt;
      bus.EX_RegRd    <= bus.ID_RegRd;
      bus.EX_RsData   <= rs_cap;
      bus.EX_RtData   <= rt_cap;
      bus.EX_Imm      <= bus.ID_Imm;
      bus.EX_ALUOp    <= bus.ID_ALUOp;
      bus.EX_ALUSrc   <= bus.ID_ALUSrc;
      bus.EX_RegWrite <= bus.ID_RegWrite;
      bus.EX_MemRead  <= bus.ID_MemRead;
      bus.EX_MemWrite <= bus.ID_MemWrite;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'h0000;
    end else if (bus.stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
